// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU selects, sequencer states and instruction field layout
// for the mini CPU control unit.
package cpu_pkg;

    localparam int OP_W  = 3;
    localparam int IMM_W = 7;

    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_LOAD    = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD     = 3'b001;
    localparam logic [OP_W-1:0] OP_ADDI    = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB     = 3'b011;
    localparam logic [OP_W-1:0] OP_SUBI    = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL     = 3'b101;
    localparam logic [OP_W-1:0] OP_CLEAR   = 3'b110;
    localparam logic [OP_W-1:0] OP_DISPLAY = 3'b111;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_MUL    = 3'd2;
    localparam logic [2:0] ALU_PASS_B = 3'd3;

    // OFF must encode as zero so state_dbg reads 0 out of reset.
    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_CLEAR     = 4'd1,
        ST_IDLE      = 4'd2,
        ST_FETCH     = 4'd3,
        ST_DECODE    = 4'd4,
        ST_EXECUTE   = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_LCD       = 4'd7
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       use_imm;
    } decode_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw push-button followed by a registered
// rising-edge detector producing a single-cycle pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    // sync_q[1] is the synchronized level, sync_q[2] its one-cycle-old copy.
    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], btn_i};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Control unit for the mini CPU: fetches switch instructions on send, drives
// the external register file and ALU, and reports each result to the LCD writer.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               power,
    input  logic               send,
    input  logic [INSTR_W-1:0] switches,
    output logic [REG_AW-1:0]  rf_rd_addr1,
    output logic [REG_AW-1:0]  rf_rd_addr2,
    input  logic [DATA_W-1:0]  rf_rd_data1,
    input  logic [DATA_W-1:0]  rf_rd_data2,
    output logic               rf_wr_en,
    output logic [REG_AW-1:0]  rf_wr_addr,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               lcd_req,
    output logic [2:0]         lcd_opcode,
    output logic [REG_AW-1:0]  lcd_dest,
    output logic [DATA_W-1:0]  lcd_value,
    input  logic               lcd_done,
    output logic               busy,
    output logic [3:0]         state_dbg
);

    state_t              state_q, state_d;
    logic [REG_AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [2:0]          lcd_op_q, lcd_op_d;
    logic [REG_AW-1:0]   lcd_dest_q, lcd_dest_d;
    logic [DATA_W-1:0]   lcd_val_q, lcd_val_d;

    logic                send_pulse;
    logic [OP_W-1:0]     op_f;
    logic [REG_AW-1:0]   rd_f, rs1_f, rs2_f;
    logic [IMM_W-1:0]    imm_f;
    logic [DATA_W-1:0]   imm_ext;
    decode_t             dec;

    function automatic decode_t decode_op(input logic [OP_W-1:0] op);
        decode_t d;
        d.alu_op  = ALU_PASS_B;
        d.use_imm = 1'b1;
        case (op)
            OP_ADD:  begin d.alu_op = ALU_ADD; d.use_imm = 1'b0; end
            OP_ADDI: d.alu_op = ALU_ADD;
            OP_SUB:  begin d.alu_op = ALU_SUB; d.use_imm = 1'b0; end
            OP_SUBI: d.alu_op = ALU_SUB;
            OP_MUL:  begin d.alu_op = ALU_MUL; d.use_imm = 1'b0; end
            default: ;
        endcase
        return d;
    endfunction

    btn_edge_sync u_send_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .btn_i   (send),
        .pulse_o (send_pulse)
    );

    assign op_f    = instr_q[OP_MSB:OP_LSB];
    assign rd_f    = instr_q[RD_MSB:RD_LSB];
    assign rs1_f   = instr_q[RS1_MSB:RS1_LSB];
    assign rs2_f   = instr_q[RS2_MSB:RS2_LSB];
    assign imm_f   = instr_q[IMM_MSB:IMM_LSB];
    assign imm_ext = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
    assign dec     = decode_op(op_f);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = '0;
        instr_d    = instr_q;
        result_d   = result_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        lcd_op_d   = lcd_op_q;
        lcd_dest_d = lcd_dest_q;
        lcd_val_d  = lcd_val_q;
        case (state_q)
            ST_OFF: if (power) state_d = ST_CLEAR;
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + REG_AW'(1);
                if (clr_cnt_q == '1) begin
                    state_d    = ST_LCD;
                    lcd_op_d   = OP_CLEAR;
                    lcd_dest_d = '0;
                    lcd_val_d  = '0;
                end
            end
            ST_IDLE: if (send_pulse) state_d = ST_FETCH;
            ST_FETCH: begin
                instr_d = switches;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_a_d  = rf_rd_data1;
                alu_b_d  = dec.use_imm ? imm_ext : rf_rd_data2;
                alu_op_d = dec.alu_op;
                state_d  = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                result_d = alu_result;
                case (op_f)
                    OP_CLEAR: state_d = ST_CLEAR;
                    OP_DISPLAY: begin
                        lcd_op_d   = OP_DISPLAY;
                        lcd_dest_d = rs1_f;
                        lcd_val_d  = rf_rd_data1;
                        state_d    = ST_LCD;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_WRITEBACK: begin
                lcd_op_d   = op_f;
                lcd_dest_d = rd_f;
                lcd_val_d  = result_q;
                state_d    = ST_LCD;
            end
            ST_LCD: if (lcd_done) state_d = ST_IDLE;
            default: state_d = ST_OFF;
        endcase
        // Losing power wins over everything, abandoning any clear in flight.
        if (!power) begin
            state_d   = ST_OFF;
            clr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            clr_cnt_q  <= '0;
            instr_q    <= '0;
            result_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            lcd_op_q   <= '0;
            lcd_dest_q <= '0;
            lcd_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            instr_q    <= instr_d;
            result_q   <= result_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            lcd_op_q   <= lcd_op_d;
            lcd_dest_q <= lcd_dest_d;
            lcd_val_q  <= lcd_val_d;
        end
    end

    // Strobes decode straight from the state so a reset drops them at once.
    assign rf_wr_en    = (state_q == ST_CLEAR) || (state_q == ST_WRITEBACK);
    assign rf_wr_addr  = (state_q == ST_CLEAR) ? clr_cnt_q :
                         (state_q == ST_WRITEBACK) ? rd_f : '0;
    assign rf_wr_data  = (state_q == ST_WRITEBACK) ? result_q : '0;
    assign rf_rd_addr1 = (state_q == ST_DECODE || state_q == ST_EXECUTE) ? rs1_f : '0;
    assign rf_rd_addr2 = (state_q == ST_DECODE || state_q == ST_EXECUTE) ? rs2_f : '0;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign lcd_req     = (state_q == ST_LCD);
    assign lcd_opcode  = lcd_op_q;
    assign lcd_dest    = lcd_dest_q;
    assign lcd_value   = lcd_val_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_OFF);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a behavioural register file, ALU and
// LCD writer around it; expected values are worked out by hand.
module tb_cpu_sequencer;

    localparam logic [31:0] S_OFF = 32'd0, S_CLEAR = 32'd1, S_IDLE = 32'd2, S_FETCH = 32'd3;
    localparam logic [31:0] S_DECODE = 32'd4, S_EXECUTE = 32'd5, S_WB = 32'd6, S_LCD = 32'd7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        power = 1'b1;
    logic        send = 1'b0;
    logic [17:0] switches = '0;
    logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr, lcd_dest;
    logic [15:0] rf_rd_data1, rf_rd_data2, rf_wr_data, alu_a, alu_b, alu_result, lcd_value;
    logic [2:0]  alu_op, lcd_opcode;
    logic        rf_wr_en, lcd_req, busy;
    logic        lcd_done = 1'b0;
    logic [3:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int w0;
    logic [15:0] rf_mem [16];

    cpu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .power(power), .send(send), .switches(switches),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .lcd_req(lcd_req), .lcd_opcode(lcd_opcode), .lcd_dest(lcd_dest),
        .lcd_value(lcd_value), .lcd_done(lcd_done), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
            wr_count <= wr_count + 1;
        end
    end
    assign rf_rd_data1 = rf_mem[rf_rd_addr1];
    assign rf_rd_data2 = rf_mem[rf_rd_addr2];

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a * alu_b;
            3'd3:    alu_result = alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [31:0] st, input int budget);
        int n = 0;
        while (32'(state_dbg) !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state_dbg), st);
    endtask

    task automatic issue(input logic [17:0] ins);
        switches = ins;
        send = 1'b1;
        @(negedge clk);
        wait_state("fetch_reached", S_FETCH, 12);
        send = 1'b0;
    endtask

    task automatic exec_write(input string tag, input logic [17:0] ins,
                              input logic [3:0] rd, input logic [15:0] val);
        logic [2:0] op;
        op = ins[17:15];
        issue(ins);
        @(negedge clk); chk({tag, "_decode"}, 32'(state_dbg), S_DECODE);
        @(negedge clk); chk({tag, "_execute"}, 32'(state_dbg), S_EXECUTE);
        chk({tag, "_no_early_wr"}, 32'(rf_wr_en), 32'd0);
        @(negedge clk); chk({tag, "_wb"}, 32'(state_dbg), S_WB);
        chk({tag, "_wr_en"}, 32'(rf_wr_en), 32'd1);
        chk({tag, "_wr_addr"}, 32'(rf_wr_addr), 32'(rd));
        chk({tag, "_wr_data"}, 32'(rf_wr_data), 32'(val));
        @(negedge clk); chk({tag, "_lcd_req"}, 32'(lcd_req), 32'd1);
        chk({tag, "_lcd_fields"}, 32'({lcd_opcode, lcd_dest, lcd_value}), 32'({op, rd, val}));
        lcd_done = 1'b1;
        @(negedge clk); lcd_done = 1'b0;
        chk({tag, "_idle"}, 32'({state_dbg, lcd_req}), 32'({4'd2, 1'b0}));
        $display("[TB] %s ins=%05h -> r%0d=%04h", tag, ins, rd, val);
    endtask

    task automatic exec_display(input string tag, input logic [3:0] rs,
                                input logic [15:0] val, input int hold);
        int wd;
        issue({3'b111, 4'd0, rs, 7'd0});
        wd = wr_count;
        @(negedge clk); chk({tag, "_decode"}, 32'(state_dbg), S_DECODE);
        @(negedge clk); chk({tag, "_execute"}, 32'(state_dbg), S_EXECUTE);
        @(negedge clk); chk({tag, "_lcd_at_n4"}, 32'({state_dbg, lcd_req}), 32'({4'd7, 1'b1}));
        chk({tag, "_lcd_fields"}, 32'({lcd_opcode, lcd_dest, lcd_value}), 32'({3'b111, rs, val}));
        for (int i = 0; i < hold; i++) begin
            if (i == 2) send = 1'b1;
            if (i == 9) send = 1'b0;
            @(negedge clk);
            chk({tag, "_hold"}, 32'({lcd_req, lcd_opcode, lcd_dest, lcd_value}),
                32'({1'b1, 3'b111, rs, val}));
        end
        chk({tag, "_no_write"}, 32'(wr_count), 32'(wd));
        lcd_done = 1'b1;
        @(negedge clk); lcd_done = 1'b0;
        chk({tag, "_idle"}, 32'(state_dbg), S_IDLE);
        repeat (8) @(negedge clk);
        chk({tag, "_send_discarded"}, 32'(state_dbg), S_IDLE);
        $display("[TB] %s r%0d shows %04h after %0d wait cycles", tag, rs, val, hold);
    endtask

    task automatic finish_clear(input string tag);
        repeat (15) @(negedge clk);
        chk({tag, "_last_addr"}, 32'({state_dbg, rf_wr_en, rf_wr_addr}), 32'({4'd1, 1'b1, 4'd15}));
        @(negedge clk);
        chk({tag, "_lcd"}, 32'({state_dbg, lcd_req, lcd_opcode, lcd_value}),
            32'({4'd7, 1'b1, 3'b110, 16'h0000}));
        lcd_done = 1'b1;
        @(negedge clk); lcd_done = 1'b0;
        chk({tag, "_idle"}, 32'(state_dbg), S_IDLE);
        $display("[TB] %s complete", tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state_dbg), S_OFF);
        chk("rst_strobes", 32'({rf_wr_en, lcd_req, busy}), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_lcd", 32'({lcd_opcode, lcd_dest, lcd_value}), 32'd0);
        $display("[TB] reset values checked");

        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("pwr_clear_step", 32'({state_dbg, rf_wr_en, rf_wr_addr, rf_wr_data}),
                32'({4'd1, 1'b1, 4'(i), 16'h0000}));
        end
        @(negedge clk);
        chk("pwr_clear_lcd", 32'({lcd_req, lcd_opcode, lcd_value}), 32'({1'b1, 3'b110, 16'h0000}));
        lcd_done = 1'b1;
        @(negedge clk); lcd_done = 1'b0;
        chk("pwr_clear_idle", 32'({state_dbg, busy}), 32'({4'd2, 1'b0}));
        $display("[TB] power-on clear complete");

        exec_write("load_r3_m5",  {3'b000, 4'd3,  4'd0,  7'h7B},          4'd3,  16'hFFFB);
        exec_write("load_r10_32", {3'b000, 4'd10, 4'd0,  7'h20},          4'd10, 16'h0020);
        exec_write("mul_r11",     {3'b101, 4'd11, 4'd10, 4'd10, 3'b000},  4'd11, 16'h0400);
        exec_write("mul_r12",     {3'b101, 4'd12, 4'd11, 4'd10, 3'b000},  4'd12, 16'h8000);
        exec_write("subi_r1",     {3'b100, 4'd1,  4'd12, 7'h01},          4'd1,  16'h7FFF);
        exec_write("load_r2_2",   {3'b000, 4'd2,  4'd0,  7'h02},          4'd2,  16'h0002);
        exec_write("addi_r7_m3",  {3'b010, 4'd7,  4'd2,  7'h7D},          4'd7,  16'hFFFF);
        exec_write("add_r4",      {3'b001, 4'd4,  4'd1,  4'd2, 3'b000},   4'd4,  16'h8001);
        exec_write("mul_r5",      {3'b101, 4'd5,  4'd1,  4'd2, 3'b000},   4'd5,  16'hFFFE);
        exec_write("sub_r6",      {3'b011, 4'd6,  4'd2,  4'd1, 3'b000},   4'd6,  16'h8003);

        exec_display("disp_r4", 4'd4, 16'h8001, 20);

        issue({3'b110, 15'd0});
        @(negedge clk); chk("iclr_decode", 32'(state_dbg), S_DECODE);
        @(negedge clk); chk("iclr_execute", 32'(state_dbg), S_EXECUTE);
        @(negedge clk); chk("iclr_first", 32'({state_dbg, rf_wr_addr}), 32'({4'd1, 4'd0}));
        repeat (7) @(negedge clk);
        chk("iclr_addr7", 32'({state_dbg, rf_wr_addr}), 32'({4'd1, 4'd7}));
        power = 1'b0;
        @(negedge clk);
        chk("pdrop_off", 32'({state_dbg, rf_wr_en, busy, lcd_req}), 32'({4'd0, 3'b000}));
        w0 = wr_count;
        repeat (5) @(negedge clk);
        chk("pdrop_no_writes", 32'(wr_count), 32'(w0));
        chk("pdrop_r5_cleared", 32'(rf_mem[5]), 32'h0000);
        chk("pdrop_r12_kept", 32'(rf_mem[12]), 32'h8000);
        $display("[TB] power dropped at clear address 7");
        power = 1'b1;
        @(negedge clk);
        chk("repower_addr0", 32'({state_dbg, rf_wr_en, rf_wr_addr}), 32'({4'd1, 1'b1, 4'd0}));
        finish_clear("repower_clear");
        chk("repower_r12_cleared", 32'(rf_mem[12]), 32'h0000);

        exec_display("disp_r5", 4'd5, 16'h0000, 0);

        issue({3'b000, 4'd3, 4'd0, 7'h05});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("rst_wb_entered", 32'({state_dbg, rf_wr_en}), 32'({4'd6, 1'b1}));
        w0 = wr_count;
        #2 reset_n = 1'b0;
        #1 chk("rst_async", 32'({state_dbg, rf_wr_en, busy, lcd_req}), 32'({4'd0, 3'b000}));
        @(negedge clk);
        power = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_no_partial_write", 32'(wr_count), 32'(w0));
        chk("rst_r3_unchanged", 32'(rf_mem[3]), 32'h0000);
        send = 1'b1;
        repeat (4) @(negedge clk);
        send = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_send_ignored", 32'({state_dbg, busy}), 32'({4'd0, 1'b0}));
        chk("rst_still_no_write", 32'(wr_count), 32'(w0));
        $display("[TB] reset asserted in writeback");
        power = 1'b1;
        @(negedge clk);
        chk("rst_repower_addr0", 32'({state_dbg, rf_wr_addr}), 32'({4'd1, 4'd0}));
        finish_clear("rst_clear");

        exec_write("load_r0_63", {3'b000, 4'd0, 4'd0, 7'h3F}, 4'd0, 16'h003F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Control unit for the mini CPU datapath. It samples an 18-bit instruction from the board switches on each `send` press, decodes it, and drives the register file (16 × 16-bit) and the combinational ALU. It then hands the result to the LCD writer through a req/done handshake. It also sequences power-on register clearing and power-off.

## Interface
Parameters:
- DATA_W, 16, register/ALU word width
- REG_AW, 4, register address width (16 registers)
- INSTR_W, 18, instruction width (switch count)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- power  in  1  level, synchronous to clk; 1 = CPU on
- send  in  1  raw push-button; 2-FF synchronized internally, rising edge used
- switches  in  18  instruction word, sampled in FETCH
- rf_rd_addr1 / rf_rd_addr2  out  4  register read addresses
- rf_rd_data1 / rf_rd_data2  in  16  combinational read data (same cycle)
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_addr  out  4  write address
- rf_wr_data  out  16  write data
- alu_a / alu_b  out  16  ALU operands
- alu_op  out  3  ALU operation
- alu_result  in  16  combinational ALU result
- lcd_req  out  1  LCD update request, held until done
- lcd_opcode  out  3  instruction opcode to display
- lcd_dest  out  4  destination/source register shown
- lcd_value  out  16  value to display
- lcd_done  in  1  one-cycle pulse from the LCD writer
- busy  out  1  high in every state except IDLE and OFF
- state_dbg  out  4  current state encoding

## Operation
- Instruction fields: op[17:15], rd[14:11], rs1[10:7], rs2[6:3], imm[6:0].
  - imm is a signed 7-bit value, sign-extended to 16 bits.
- Opcodes:
  - 000 LOAD: rd ← imm
  - 001 ADD: rd ← rs1+rs2
  - 010 ADDI: rd ← rs1+imm
  - 011 SUB: rd ← rs1−rs2
  - 100 SUBI: rd ← rs1−imm
  - 101 MUL: rd ← low16(rs1·rs2)
  - 110 CLEAR: all 16 registers ← 0
  - 111 DISPLAY: no write, lcd_value ← rs1
- Arithmetic wraps modulo 2^16. Signed and unsigned results are bit-identical.
- Register 0 is an ordinary register.
- States: OFF, CLEAR, IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, LCD.
  - OFF → CLEAR when power=1.
  - CLEAR: writes 0 to addresses 0..15, one per cycle, via a 4-bit counter. After address 15 it goes to LCD with lcd_opcode=110, lcd_value=0.
  - IDLE → FETCH on a synchronized send rising edge.
  - FETCH latches switches into the instruction register, then goes to DECODE.
  - DECODE drives rf_rd_addr1=rs1 and rf_rd_addr2=rs2. It selects alu_b = rs2 data or sign-extended imm, then goes to EXECUTE.
  - EXECUTE registers alu_result into the result register.
    - Opcode 110 goes to CLEAR.
    - Opcode 111 latches rs1 data and goes to LCD.
    - All other opcodes go to WRITEBACK.
  - WRITEBACK asserts rf_wr_en for one cycle (addr=rd, data=result), then goes to LCD.
  - LCD holds lcd_req=1 with stable lcd_opcode, lcd_dest and lcd_value until lcd_done is sampled high. It then goes to IDLE.
- power=0 in any state: next state is OFF. rf_wr_en and lcd_req drop the same edge, and a CLEAR in progress is abandoned.
- send edges outside IDLE are discarded, not queued. lcd_done outside LCD is ignored.

## Timing
- Reset values:
  - state = OFF
  - all outputs 0, including rf_wr_en, lcd_req, busy and alu_op
  - instruction/result registers 0
  - synchronizer flops 0
- send edge to pulse: 2 cycles of synchronization plus 1 cycle of edge detect.
- Edge pulse seen in IDLE at cycle N gives:
  - FETCH at N+1
  - DECODE at N+2
  - EXECUTE at N+3
  - WRITEBACK at N+4, with rf_wr_en=1 at N+4
  - lcd_req rising at N+5
  - DISPLAY skips WRITEBACK, so lcd_req rises at N+4.
- lcd_done high at cycle M gives lcd_req=0 and IDLE at M+1. A zero-wait writer (done in the first req cycle) is legal.
- Power-on clear: 16 write cycles, then LCD. Instruction CLEAR: EXECUTE, then 16 writes, then LCD.
- Asynchronous reset mid-operation: immediate return to the reset values. No partial write completes after reset assertion.

## Structure
- Package cpu_pkg holds:
  - opcode constants: OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLEAR, OP_DISPLAY
  - ALU op constants: ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_PASS_B=3
  - state enum
  - field bit positions
- One sub-module, btn_edge_sync: 2-FF synchronizer plus rising-edge pulse for send.
- Decode (opcode to alu_op and B-mux select) is a combinational function inside cpu_sequencer.

## Test plan
- Reset release with power=1: 16 writes of 0 to addresses 0..15, then lcd_req with opcode 110; done pulse returns to IDLE.
- LOAD r3,#−5 (switches = 000_0011_0000_1111011): rf_wr_en at N+4 with addr 3, data 0xFFFB; lcd_value 0xFFFB, lcd_dest 3.
- With r1=0x7FFF and r2=0x0002: ADD r4,r1,r2 writes 0x8001; MUL r5,r1,r2 writes 0xFFFE; SUB r6,r2,r1 writes 0x8003.
- DISPLAY r4: no rf_wr_en, lcd_req at N+4 with value 0x8001. Holding lcd_done low for 20 cycles keeps lcd_req and data stable. A send press during LCD is ignored.
- power drops during CLEAR at address 7: next cycle OFF, no further writes, busy=0. Power back on restarts clearing at address 0.
- reset_n asserted in WRITEBACK: rf_wr_en falls asynchronously, state reads OFF, and a following send does nothing until power is high and clearing completes.
